// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg: shared types and constants for the sleep controller.
package cv32e40s_pkg;

   localparam int SLEEP_CNT_W = 8;

   typedef enum logic [2:0] {
      S_RUN,
      S_DRAIN,
      S_SETTLE,
      S_SLEEP,
      S_WAKE
   } sleep_state_e;

   // Counters run down to 0, so a wait of n cycles loads n-1.
   function automatic logic [SLEEP_CNT_W-1:0] cnt_load(input int n);
      return SLEEP_CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/cv32e40s_sleep_ctrl.sv
// cv32e40s_sleep_ctrl: WFI sleep sequencer driving the parent's clock-gate enable.
// Outputs come from registers only, so reset alone reopens the gate.
module cv32e40s_sleep_ctrl
   import cv32e40s_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int WAKE_CYCLES   = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wfi_req_i,
   input  logic core_idle_i,
   input  logic wake_i,
   output logic gate_en_o,
   output logic sleeping_o,
   output logic wake_ack_o
);

   sleep_state_e             r_state;
   sleep_state_e             w_state_nxt;
   logic [SLEEP_CNT_W-1:0]   r_cnt;
   logic [SLEEP_CNT_W-1:0]   w_cnt_nxt;
   logic                     r_ack;
   logic                     w_ack_nxt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (wfi_req_i && !wake_i) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (wake_i) begin
               w_state_nxt = S_RUN;
            end else if (core_idle_i) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = cnt_load(SETTLE_CYCLES);
            end
         end
         S_SETTLE: begin
            if (wake_i) begin
               w_state_nxt = S_RUN;
            end else if (!core_idle_i) begin
               w_state_nxt = S_DRAIN;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_SLEEP;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_SLEEP: begin
            if (wake_i) begin
               w_state_nxt = S_WAKE;
               w_cnt_nxt   = cnt_load(WAKE_CYCLES);
            end
         end
         S_WAKE: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RUN;
               w_ack_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   assign gate_en_o  = r_state != S_SLEEP;
   assign sleeping_o = r_state == S_SLEEP || r_state == S_WAKE;
   assign wake_ack_o = r_ack;

   always_ff @(posedge clk_i) begin
      assert (SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 255) else $error("SETTLE_CYCLES out of range");
      assert (WAKE_CYCLES >= 1 && WAKE_CYCLES <= 255) else $error("WAKE_CYCLES out of range");
   end

endmodule

// File: tb/tb_cv32e40s_sleep_ctrl.sv
// tb_cv32e40s_sleep_ctrl: directed and random checks of two parameterisations against a cycle model.
module tb_cv32e40s_sleep_ctrl;

   localparam int M_RUN = 0, M_DRAIN = 1, M_SETTLE = 2, M_SLEEP = 3, M_WAKE = 4;

   logic clk, rst, wfi, idle, wake;
   logic [1:0] gate, slp, ack;

   int checks = 0;
   int errors = 0;
   int mode[2];
   int left[2];
   bit mack[2];
   int sc[2] = '{2, 1};
   int wc[2] = '{2, 1};

   cv32e40s_sleep_ctrl u_dut0 (
      .clk_i(clk), .rst_i(rst), .wfi_req_i(wfi), .core_idle_i(idle), .wake_i(wake),
      .gate_en_o(gate[0]), .sleeping_o(slp[0]), .wake_ack_o(ack[0])
   );

   cv32e40s_sleep_ctrl #(.SETTLE_CYCLES(1), .WAKE_CYCLES(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .wfi_req_i(wfi), .core_idle_i(idle), .wake_i(wake),
      .gate_en_o(gate[1]), .sleeping_o(slp[1]), .wake_ack_o(ack[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mode[k] = M_RUN;
         left[k] = 0;
         mack[k] = 1'b0;
      end
   endtask

   // left = cycles still to spend in the current timed phase
   task automatic model_step(input int k);
      mack[k] = 1'b0;
      case (mode[k])
         M_RUN:    if (wfi && !wake) mode[k] = M_DRAIN;
         M_DRAIN:  if (wake) mode[k] = M_RUN;
                   else if (idle) begin mode[k] = M_SETTLE; left[k] = sc[k]; end
         M_SETTLE: if (wake) mode[k] = M_RUN;
                   else if (!idle) mode[k] = M_DRAIN;
                   else begin left[k]--; if (left[k] == 0) mode[k] = M_SLEEP; end
         M_SLEEP:  if (wake) begin mode[k] = M_WAKE; left[k] = wc[k]; end
         default:  begin left[k]--; if (left[k] == 0) begin mode[k] = M_RUN; mack[k] = 1'b1; end end
      endcase
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("gate%0d", k), gate[k], mode[k] != M_SLEEP);
         check($sformatf("sleeping%0d", k), slp[k], mode[k] == M_SLEEP || mode[k] == M_WAKE);
         check($sformatf("wake_ack%0d", k), ack[k], mack[k]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b1; wfi = 1'b0; idle = 1'b0; wake = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_gate", gate[0], 1'b1);
      check("rst_sleeping", slp[0], 1'b0);
      check("rst_ack", ack[0], 1'b0);
      rst = 1'b0;
      tick();

      // gate-off latency: default gates on 4th edge, 1/1 variant on 3rd
      wfi = 1'b1; idle = 1'b1;
      tick(); wfi = 1'b0;
      check("lat_d1", gate[0], 1'b1);
      tick();
      tick();
      check("lat_d3", gate[0], 1'b1);
      check("lat_s3", gate[1], 1'b0);
      tick();
      check("lat_d4", gate[0], 1'b0);

      // idle ignored in sleep, then one-cycle wake
      idle = 1'b0; wfi = 1'b1;
      tick();
      check("sleep_hold", gate[0], 1'b0);
      wake = 1'b1; wfi = 1'b0;
      tick(); wake = 1'b0;
      check("wake_gate", gate[0], 1'b1);
      check("wake_slp", slp[0], 1'b1);
      tick();
      check("wake_ack_s", ack[1], 1'b1);
      check("wake_slp2", slp[0], 1'b1);
      tick();
      check("wake_ack_d", ack[0], 1'b1);
      check("wake_slp3", slp[0], 1'b0);
      tick();
      check("ack_once", ack[0], 1'b0);

      // wfi with wake pending stays in RUN
      wfi = 1'b1; wake = 1'b1; idle = 1'b1;
      tick(); tick();
      check("wfi_wake_gate", gate[0], 1'b1);
      check("wfi_wake_slp", slp[0], 1'b0);

      // idle drop in SETTLE forces full recount
      wake = 1'b0;
      tick(); wfi = 1'b0;
      tick();
      idle = 1'b0;
      tick();
      idle = 1'b1;
      tick();
      tick();
      check("recount_open", gate[0], 1'b1);
      tick();
      check("recount_gate", gate[0], 1'b0);

      // asynchronous reset mid-sleep
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("arst_gate0", gate[0], 1'b1);
      check("arst_gate1", gate[1], 1'b1);
      check("arst_slp", slp[0], 1'b0);
      check("arst_ack", ack[0], 1'b0);
      tick();
      rst = 1'b0;
      tick();
      check("arst_noack", ack[0], 1'b0);

      for (int i = 0; i < 800; i++) begin
         wfi  = $urandom_range(3) == 0;
         idle = $urandom_range(4) != 0;
         wake = $urandom_range(9) == 0;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
